// File: rtl/voice_mix_seq.sv
// Time-multiplexed voice mixer: walks the voice store once per sample strobe,
// sums the unmuted signed samples and publishes a saturated result.
module voice_mix_seq #(
   parameter int NVOICE = 8,
   parameter int VSZ    = 16,
   parameter int ASZ    = 19,
   parameter int OSZ    = 16,
   parameter int AW     = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ena,
   input  logic [NVOICE-1:0]     voice_mute,
   output logic [AW-1:0]         voice_addr,
   input  logic signed [VSZ-1:0] voice_dat,
   output logic [OSZ-1:0]        out_dat,
   output logic                  out_vld,
   output logic                  out_clip,
   output logic                  busy,
   input  logic                  clr,
   output logic [7:0]            clip_cnt,
   output logic                  overrun
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_SAT   = 2'd3
   } state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(NVOICE - 1);
   localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

   state_t                r_state;
   state_t                w_next;
   logic [NVOICE-1:0]     r_mask;
   logic signed [ASZ-1:0] r_acc;
   logic                  r_dv;
   logic                  r_dv_mute;
   logic [AW-1:0]         r_addr;
   logic                  r_busy;
   logic [OSZ-1:0]        r_out_dat;
   logic                  r_out_vld;
   logic                  r_out_clip;
   logic [7:0]            r_clip_cnt;
   logic                  r_overrun;
   logic                  w_start;
   logic                  w_fetch;
   logic                  w_sat;
   logic                  w_ena_busy;
   logic signed [ASZ-1:0] w_sample;
   logic [OSZ:0]          w_sat_res;

   // Clamp to OSZ bits; bit OSZ of the result flags that clamping happened.
   function automatic logic [OSZ:0] saturate(input logic signed [ASZ-1:0] a);
      logic [ASZ-OSZ:0] top;
      top = a[ASZ-1:OSZ-1];
      if ((&top) || !(|top)) begin
         saturate = {1'b0, a[OSZ-1:0]};
      end else if (a[ASZ-1]) begin
         saturate = {1'b1, 1'b1, {(OSZ-1){1'b0}}};
      end else begin
         saturate = {1'b1, 1'b0, {(OSZ-1){1'b1}}};
      end
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; DRAIN covers the final accumulate while the store pipeline empties.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (ena) w_next = S_FETCH;
            else     w_next = S_IDLE;
         end
         S_FETCH: begin
            if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            else                     w_next = S_FETCH;
         end
         S_DRAIN: w_next = S_SAT;
         S_SAT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output/control decode of the current state.
   always_comb begin
      w_start    = 1'b0;
      w_fetch    = 1'b0;
      w_sat      = 1'b0;
      w_ena_busy = 1'b0;
      case (r_state)
         S_IDLE:  w_start    = ena;
         S_FETCH: begin
            w_fetch    = 1'b1;
            w_ena_busy = ena;
         end
         S_DRAIN: w_ena_busy = ena;
         S_SAT: begin
            w_sat      = 1'b1;
            w_ena_busy = ena;
         end
         default: w_start = 1'b0;
      endcase
   end

   assign w_sample  = {{(ASZ-VSZ){voice_dat[VSZ-1]}}, voice_dat};
   assign w_sat_res = saturate(r_acc);

   // Address walk and accumulation; data lags the address by one cycle, so a
   // one-stage valid/mute pipe lines each sample up with its mask bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mask    <= {NVOICE{1'b0}};
         r_acc     <= {ASZ{1'b0}};
         r_dv      <= 1'b0;
         r_dv_mute <= 1'b0;
         r_addr    <= {AW{1'b0}};
         r_busy    <= 1'b0;
      end else begin
         r_dv      <= w_fetch;
         r_dv_mute <= r_mask[r_addr];
         if (w_start) begin
            r_mask <= voice_mute;
            r_acc  <= {ASZ{1'b0}};
            r_addr <= {AW{1'b0}};
            r_busy <= 1'b1;
         end else begin
            if (r_dv && !r_dv_mute) begin
               r_acc <= r_acc + w_sample;
            end
            if (w_fetch && (r_addr != LAST_ADDR)) begin
               r_addr <= r_addr + ADDR_ONE;
            end
            if (w_sat) begin
               r_busy <= 1'b0;
            end
         end
      end
   end

   // Result publication.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_dat  <= {OSZ{1'b0}};
         r_out_vld  <= 1'b0;
         r_out_clip <= 1'b0;
      end else begin
         r_out_vld  <= w_sat;
         r_out_clip <= w_sat & w_sat_res[OSZ];
         if (w_sat) begin
            r_out_dat <= w_sat_res[OSZ-1:0];
         end
      end
   end

   // Status for the control interface; clr dominates any same-cycle update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clip_cnt <= 8'd0;
         r_overrun  <= 1'b0;
      end else if (clr) begin
         r_clip_cnt <= 8'd0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_sat && w_sat_res[OSZ] && (r_clip_cnt != 8'hFF)) begin
            r_clip_cnt <= r_clip_cnt + 8'd1;
         end
         if (w_ena_busy) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign voice_addr = r_addr;
   assign out_dat    = r_out_dat;
   assign out_vld    = r_out_vld;
   assign out_clip   = r_out_clip;
   assign busy       = r_busy;
   assign clip_cnt   = r_clip_cnt;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_voice_mix_seq.sv
// Scoreboard bench for voice_mix_seq: expected mixes are queued at the strobe
// and matched against the out_vld pulses captured by a monitor.
module tb_voice_mix_seq;

   logic              clk = 1'b0;
   logic              reset;
   logic              ena;
   logic              clr;
   logic [7:0]        voice_mute;
   logic [2:0]        voice_addr;
   logic signed [15:0] voice_dat;
   logic [15:0]       out_dat;
   logic              out_vld;
   logic              out_clip;
   logic              busy;
   logic [7:0]        clip_cnt;
   logic              overrun;

   int errors  = 0;
   int checks  = 0;
   int cyc     = 0;
   int ena_cyc = 0;

   logic signed [15:0] mem [8];
   logic [16:0] exp_q[$];
   logic [15:0] obs_dat_q[$];
   logic        obs_clip_q[$];
   int          obs_cyc_q[$];

   voice_mix_seq dut (
      .clk(clk), .reset(reset), .ena(ena), .voice_mute(voice_mute),
      .voice_addr(voice_addr), .voice_dat(voice_dat), .out_dat(out_dat),
      .out_vld(out_vld), .out_clip(out_clip), .busy(busy), .clr(clr),
      .clip_cnt(clip_cnt), .overrun(overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Voice store model: registered read, data one cycle after the address.
   always @(posedge clk) voice_dat <= mem[voice_addr];

   always @(negedge clk) begin
      if (out_vld === 1'b1) begin
         obs_dat_q.push_back(out_dat);
         obs_clip_q.push_back(out_clip);
         obs_cyc_q.push_back(cyc);
      end
   end

   function automatic logic [16:0] model_mix(input logic [7:0] m);
      int s;
      logic [15:0] d;
      s = 0;
      for (int i = 0; i < 8; i++) if (!m[i]) s += int'(mem[i]);
      if (s > 32767) model_mix = {1'b1, 16'h7FFF};
      else if (s < -32768) model_mix = {1'b1, 16'h8000};
      else begin
         d = s[15:0];
         model_mix = {1'b0, d};
      end
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ena();
      ena = 1'b1;
      ena_cyc = cyc;
      @(negedge clk);
      ena = 1'b0;
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < 8; i++) mem[i] = 16'(v);
   endtask

   task automatic clear_q();
      exp_q.delete();
      obs_dat_q.delete();
      obs_clip_q.delete();
      obs_cyc_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(1);
      checks++;
      if ({out_dat, out_vld, out_clip, busy, voice_addr, clip_cnt, overrun} !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: got dat=%0h vld=%b clip=%b busy=%b addr=%0d cnt=%0d ovr=%b, expected all zero",
                  out_dat, out_vld, out_clip, busy, voice_addr, clip_cnt, overrun);
      end
      clear_q();
   endtask

   task automatic test_nominal();
      logic [16:0] e;
      fill(1000);
      voice_mute = 8'h00;
      exp_q.push_back(model_mix(8'h00));
      pulse_ena();
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (voice_addr !== 3'(k) || busy !== 1'b1) begin
            errors++;
            $display("FAIL nominal_addr: got addr=%0d busy=%b, expected addr=%0d busy=1", voice_addr, busy, k);
         end
         @(negedge clk);
      end
      idle(5);
      checks++;
      if (obs_dat_q.size() != 1) begin
         errors++;
         $display("FAIL nominal_pulses: got %0d, expected 1", obs_dat_q.size());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (obs_dat_q[0] !== e[15:0] || obs_clip_q[0] !== e[16]) begin
            errors++;
            $display("FAIL nominal_data: got %0d clip=%b, expected %0d clip=%b",
                     $signed(obs_dat_q[0]), obs_clip_q[0], $signed(e[15:0]), e[16]);
         end
         checks++;
         if (obs_cyc_q[0] - ena_cyc !== 11) begin
            errors++;
            $display("FAIL nominal_latency: got %0d, expected 11", obs_cyc_q[0] - ena_cyc);
         end
      end
      checks++;
      if (busy !== 1'b0 || out_dat !== 16'd8000) begin
         errors++;
         $display("FAIL nominal_hold: got busy=%b dat=%0d, expected busy=0 dat=8000", busy, out_dat);
      end
      clear_q();
   endtask

   task automatic test_clip();
      logic [16:0] e;
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: fill(20000);
            1: fill(-20000);
            2: begin fill(4096); mem[7] = 16'sd4095; end
            default: fill(-4096);
         endcase
         exp_q.push_back(model_mix(8'h00));
         pulse_ena();
         idle(13);
         checks++;
         if (obs_dat_q.size() != 1) begin
            errors++;
            $display("FAIL clip_pulses[%0d]: got %0d, expected 1", c, obs_dat_q.size());
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (obs_dat_q[0] !== e[15:0] || obs_clip_q[0] !== e[16]) begin
               errors++;
               $display("FAIL clip_data[%0d]: got %0d clip=%b, expected %0d clip=%b",
                        c, $signed(obs_dat_q[0]), obs_clip_q[0], $signed(e[15:0]), e[16]);
            end
         end
         clear_q();
      end
      checks++;
      if (clip_cnt !== 8'd2) begin
         errors++;
         $display("FAIL clip_cnt: got %0d, expected 2", clip_cnt);
      end
   endtask

   task automatic test_mute();
      logic [16:0] e;
      fill(30000);
      mem[0] = -16'sd5;
      voice_mute = 8'hFE;
      exp_q.push_back(model_mix(8'hFE));
      pulse_ena();
      voice_mute = 8'h00;
      idle(4);
      voice_mute = 8'hFF;
      idle(9);
      voice_mute = 8'h00;
      checks++;
      if (obs_dat_q.size() != 1) begin
         errors++;
         $display("FAIL mute_pulses: got %0d, expected 1", obs_dat_q.size());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (obs_dat_q[0] !== e[15:0] || obs_clip_q[0] !== e[16]) begin
            errors++;
            $display("FAIL mute_data: got %0d clip=%b, expected %0d clip=%b",
                     $signed(obs_dat_q[0]), obs_clip_q[0], $signed(e[15:0]), e[16]);
         end
      end
      clear_q();
   endtask

   task automatic test_overrun();
      int first;
      fill(-300);
      pulse_ena();
      first = ena_cyc;
      idle(3);
      pulse_ena();
      idle(13);
      checks++;
      if (obs_dat_q.size() != 1 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_busy: got pulses=%0d overrun=%b, expected pulses=1 overrun=1", obs_dat_q.size(), overrun);
      end else begin
         checks++;
         if (obs_dat_q[0] !== 16'hF6A0 || obs_cyc_q[0] - first !== 11) begin
            errors++;
            $display("FAIL overrun_frame: got %0d at +%0d, expected -2400 at +11",
                     $signed(obs_dat_q[0]), obs_cyc_q[0] - first);
         end
      end
      clear_q();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      checks++;
      if (overrun !== 1'b0 || clip_cnt !== 8'd0) begin
         errors++;
         $display("FAIL clr: got overrun=%b cnt=%0d, expected 0 0", overrun, clip_cnt);
      end
   endtask

   task automatic test_sat_edge();
      pulse_ena();
      idle(9);
      pulse_ena();
      idle(14);
      checks++;
      if (obs_dat_q.size() != 1 || overrun !== 1'b1) begin
         errors++;
         $display("FAIL sat_edge_ena: got pulses=%0d overrun=%b, expected pulses=1 overrun=1", obs_dat_q.size(), overrun);
      end
      clear_q();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_back_to_back();
      int bad;
      fill(20000);
      for (int f = 0; f < 300; f++) begin
         pulse_ena();
         idle(10);
      end
      idle(4);
      bad = 0;
      for (int i = 0; i < obs_dat_q.size(); i++) begin
         if (obs_dat_q[i] !== 16'h7FFF || obs_clip_q[i] !== 1'b1) bad++;
      end
      checks++;
      if (obs_dat_q.size() != 300 || bad != 0) begin
         errors++;
         $display("FAIL b2b_frames: got %0d frames with %0d wrong, expected 300 frames all 32767 clipped",
                  obs_dat_q.size(), bad);
      end
      checks++;
      if (clip_cnt !== 8'd255 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_status: got cnt=%0d overrun=%b, expected cnt=255 overrun=0", clip_cnt, overrun);
      end
      clear_q();
   endtask

   task automatic test_reset_mid();
      logic [16:0] e;
      fill(100);
      pulse_ena();
      idle(8);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_dat !== 16'd0 || clip_cnt !== 8'd0 || voice_addr !== 3'd0) begin
         errors++;
         $display("FAIL reset_mid_state: got busy=%b dat=%0d cnt=%0d addr=%0d, expected all 0",
                  busy, out_dat, clip_cnt, voice_addr);
      end
      idle(12);
      checks++;
      if (obs_dat_q.size() != 0) begin
         errors++;
         $display("FAIL reset_mid_vld: got %0d pulses, expected 0", obs_dat_q.size());
      end
      clear_q();
      exp_q.push_back(model_mix(8'h00));
      pulse_ena();
      idle(13);
      checks++;
      if (obs_dat_q.size() != 1) begin
         errors++;
         $display("FAIL reset_mid_next: got %0d pulses, expected 1", obs_dat_q.size());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (obs_dat_q[0] !== e[15:0] || obs_cyc_q[0] - ena_cyc !== 11) begin
            errors++;
            $display("FAIL reset_mid_data: got %0d at +%0d, expected %0d at +11",
                     $signed(obs_dat_q[0]), obs_cyc_q[0] - ena_cyc, $signed(e[15:0]));
         end
      end
      clear_q();
   endtask

   initial begin
      reset = 1'b1;
      ena = 1'b0;
      clr = 1'b0;
      voice_mute = 8'h00;
      fill(0);
      @(negedge clk);
      test_reset();
      test_nominal();
      test_clip();
      test_mute();
      test_overrun();
      test_sat_edge();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
